// File: rtl/chrom_eval_pkg.sv
// Shared types and helpers for the chromosome evaluation sequencer.
// State codes, clamp helper and trace-index packing.
package chrom_eval_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_LOAD,
        S_RUN,
        S_ACCUM,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int IGNORE_CYCLES_DEF = 10;
    localparam int NUM_RETRIES_DEF   = 3;
    localparam int TRACE_IDX_W       = 8;

    function automatic int unsigned clamp_min(
        input int unsigned v,
        input int unsigned lo
    );
        return (v < lo) ? lo : v;
    endfunction

    function automatic logic [TRACE_IDX_W-1:0] trace_index(
        input int unsigned idx
    );
        return TRACE_IDX_W'(idx);
    endfunction

endpackage

// File: rtl/chrom_eval_if.sv
// Bundle between the sequencer, the GA controller, the sample ROM,
// the phenotype circuit and the trace RAM.
interface chrom_eval_if
    import chrom_eval_pkg::*;
#(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int NUM_SAMPLES = 64,
    parameter int SUM_W       = 32,
    parameter int CYC_W       = 16,
    parameter int ADDR_W      = 15
);
    localparam int IDX_W   = $clog2(NUM_SAMPLES);
    localparam int TOT_W   = SUM_W + $clog2(OUT_W);
    localparam int TRACE_W = IN_W + TRACE_IDX_W + 2 * OUT_W;

    logic                   iStart;
    logic                   iDoneAck;
    logic                   oReady;
    logic                   oDone;
    logic [IDX_W:0]         iSeqLen;
    logic [CYC_W-1:0]       iHoldCycles;
    logic                   iEarlyAbort;
    logic [IDX_W-1:0]       oSampleIdx;
    logic [IN_W-1:0]        iSampleIn;
    logic [OUT_W-1:0]       iSampleExp;
    logic [OUT_W-1:0]       iSampleValid;
    logic [IN_W-1:0]        oChromInput;
    logic                   oChromBlank;
    logic [OUT_W-1:0]       iChromOutput;
    logic [OUT_W*SUM_W-1:0] oErrorSums;
    logic [TOT_W-1:0]       oTotalErrors;
    logic [2:0]             oPassCount;
    logic [2:0]             oState;
    logic                   oTraceWe;
    logic [ADDR_W-1:0]      oTraceAddr;
    logic [TRACE_W-1:0]     oTraceData;

    modport master (
        input  iStart, iDoneAck, iSeqLen, iHoldCycles, iEarlyAbort,
        input  iSampleIn, iSampleExp, iSampleValid, iChromOutput,
        output oReady, oDone, oSampleIdx, oChromInput, oChromBlank,
        output oErrorSums, oTotalErrors, oPassCount, oState,
        output oTraceWe, oTraceAddr, oTraceData
    );

    modport slave (
        output iStart, iDoneAck, iSeqLen, iHoldCycles, iEarlyAbort,
        output iSampleIn, iSampleExp, iSampleValid, iChromOutput,
        input  oReady, oDone, oSampleIdx, oChromInput, oChromBlank,
        input  oErrorSums, oTotalErrors, oPassCount, oState,
        input  oTraceWe, oTraceAddr, oTraceData
    );

endinterface

// File: rtl/chrom_err_accum.sv
// Per-channel saturating failing-entry counters.
module chrom_err_accum #(
    parameter int OUT_W = 8,
    parameter int SUM_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [OUT_W-1:0]       inc,
    output logic [OUT_W*SUM_W-1:0] sums
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sums <= '0;
        end else begin
            for (int c = 0; c < OUT_W; c++) begin
                if (inc[c] && sums[c*SUM_W +: SUM_W] != '1)
                    sums[c*SUM_W +: SUM_W] <= sums[c*SUM_W +: SUM_W] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/chrom_eval_sequencer.sv
// Runs a sample sequence through a phenotype circuit, counts per-channel
// failures, retries clean passes and traces the final pass.
module chrom_eval_sequencer
    import chrom_eval_pkg::*;
#(
    parameter int IN_W          = 8,
    parameter int OUT_W         = 8,
    parameter int NUM_SAMPLES   = 64,
    parameter int SUM_W         = 32,
    parameter int CYC_W         = 16,
    parameter int IGNORE_CYCLES = IGNORE_CYCLES_DEF,
    parameter int NUM_RETRIES   = NUM_RETRIES_DEF,
    parameter int ADDR_W        = 15
) (
    input logic          iClock,
    input logic          iReset,
    chrom_eval_if.master bus
);

    localparam int IDX_W    = $clog2(NUM_SAMPLES);
    localparam int TOT_W    = SUM_W + $clog2(OUT_W);
    localparam int HOLD_MIN = IGNORE_CYCLES + 1;

    state_t                 state, state_nx;
    logic [IDX_W:0]         len;
    logic [CYC_W-1:0]       hold, cnt;
    logic                   abort, final_pass;
    logic [IDX_W-1:0]       idx;
    logic [OUT_W-1:0]       flags, mism, inc;
    logic [2:0]             pass;
    logic [ADDR_W-1:0]      taddr;
    logic [IN_W-1:0]        stim;
    logic [OUT_W*SUM_W-1:0] sums;
    logic [TOT_W-1:0]       total;
    logic                   sums_clr, last_hold, last_idx;

    assign mism      = (bus.iChromOutput ^ bus.iSampleExp) & bus.iSampleValid;
    assign last_hold = (cnt == hold - 1'b1);
    assign last_idx  = ({1'b0, idx} == len - 1'b1);
    assign sums_clr  = (state == S_IDLE) && bus.iStart;
    assign inc       = (state == S_ACCUM) ? flags : '0;

    always_comb begin
        total = '0;
        for (int c = 0; c < OUT_W; c++)
            total = total + TOT_W'(sums[c*SUM_W +: SUM_W]);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (bus.iStart) state_nx = S_BLANK;
            S_BLANK: state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   if (last_hold) state_nx = S_ACCUM;
            S_ACCUM: begin
                if (abort && |flags) state_nx = S_DONE;
                else if (last_idx)   state_nx = S_CHECK;
                else                 state_nx = S_LOAD;
            end
            S_CHECK: begin
                if (total == '0 && pass < 3'(NUM_RETRIES))
                    state_nx = S_LOAD;
                else
                    state_nx = S_DONE;
            end
            S_DONE:  if (bus.iDoneAck) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= S_IDLE;
            len        <= '0;
            hold       <= '0;
            abort      <= 1'b0;
            idx        <= '0;
            cnt        <= '0;
            flags      <= '0;
            pass       <= '0;
            taddr      <= '0;
            stim       <= '0;
            final_pass <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: if (bus.iStart) begin
                    len        <= (bus.iSeqLen == '0) ? {{IDX_W{1'b0}}, 1'b1}
                                                      : bus.iSeqLen;
                    hold       <= CYC_W'(clamp_min(32'(bus.iHoldCycles),
                                                   HOLD_MIN));
                    abort      <= bus.iEarlyAbort;
                    pass       <= '0;
                    idx        <= '0;
                    final_pass <= 1'b0;
                end
                S_BLANK: taddr <= '0;
                S_LOAD: begin
                    stim  <= bus.iSampleIn;
                    flags <= '0;
                    cnt   <= '0;
                    // decided once per pass, at its first entry
                    if (idx == '0)
                        final_pass <= (pass == 3'(NUM_RETRIES)) ||
                                      (total != '0);
                end
                S_RUN: begin
                    if (cnt >= CYC_W'(IGNORE_CYCLES))
                        flags <= flags | mism;
                    cnt <= cnt + 1'b1;
                    if (final_pass) taddr <= taddr + 1'b1;
                end
                S_ACCUM: begin
                    if (!(abort && |flags) && !last_idx)
                        idx <= idx + 1'b1;
                end
                S_CHECK: begin
                    pass <= pass + 1'b1;
                    idx  <= '0;
                end
                default: ;
            endcase
        end
    end

    chrom_err_accum #(
        .OUT_W (OUT_W),
        .SUM_W (SUM_W)
    ) u_accum (
        .clk  (iClock),
        .rst  (iReset),
        .clr  (sums_clr),
        .inc  (inc),
        .sums (sums)
    );

    assign bus.oReady       = (state == S_IDLE);
    assign bus.oDone        = (state == S_DONE);
    assign bus.oSampleIdx   = idx;
    assign bus.oChromInput  = stim;
    assign bus.oChromBlank  = (state == S_BLANK);
    assign bus.oErrorSums   = sums;
    assign bus.oTotalErrors = total;
    assign bus.oPassCount   = pass;
    assign bus.oState       = state;
    assign bus.oTraceWe     = (state == S_RUN) && final_pass;
    assign bus.oTraceAddr   = taddr;
    assign bus.oTraceData   = {stim, trace_index(32'(idx)),
                               bus.iSampleExp, bus.iChromOutput};

endmodule

// File: tb/tb_chrom_eval_sequencer.sv
// Bench for chrom_eval_sequencer: directed table, random configs against a
// pass-level reference model, and a reset-during-run sequence.
module tb_chrom_eval_sequencer;
    import chrom_eval_pkg::*;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 8;
    localparam int NS     = 64;
    localparam int SUM_W  = 2;
    localparam int CYC_W  = 16;
    localparam int ADDR_W = 15;
    localparam int IGN    = 10;
    localparam int RET    = 3;
    localparam int IDX_W  = $clog2(NS);
    localparam int TOT_W  = SUM_W + $clog2(OUT_W);
    localparam int TW     = IN_W + 8 + 2 * OUT_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chrom_eval_if #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_SAMPLES(NS),
        .SUM_W(SUM_W), .CYC_W(CYC_W), .ADDR_W(ADDR_W)
    ) bus ();

    chrom_eval_sequencer #(
        .IN_W(IN_W), .OUT_W(OUT_W), .NUM_SAMPLES(NS), .SUM_W(SUM_W),
        .CYC_W(CYC_W), .IGNORE_CYCLES(IGN), .NUM_RETRIES(RET),
        .ADDR_W(ADDR_W)
    ) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    // sample ROM and phenotype: output = expected, corrupted by err_m
    // during RUN cycles err_lo..err_hi of an entry
    logic [IN_W-1:0]  rom_in  [NS];
    logic [OUT_W-1:0] rom_exp [NS];
    logic [OUT_W-1:0] rom_val [NS];
    logic [OUT_W-1:0] err_m   [NS];
    int               err_lo  [NS];
    int               err_hi  [NS];
    int               run_cnt = 0;
    logic [OUT_W-1:0] glitch;

    always @(posedge clk)
        run_cnt <= (bus.oState == S_RUN) ? run_cnt + 1 : 0;

    always_comb begin
        glitch = '0;
        if (bus.oState == S_RUN &&
            run_cnt >= err_lo[bus.oSampleIdx] &&
            run_cnt <= err_hi[bus.oSampleIdx])
            glitch = err_m[bus.oSampleIdx];
    end

    assign bus.iSampleIn    = rom_in[bus.oSampleIdx];
    assign bus.iSampleExp   = rom_exp[bus.oSampleIdx];
    assign bus.iSampleValid = rom_val[bus.oSampleIdx];
    assign bus.iChromOutput = rom_exp[bus.oSampleIdx] ^ glitch;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // reference model results
    logic [TW-1:0]          m_trace [$];
    logic [OUT_W*SUM_W-1:0] m_sums;
    logic [TOT_W-1:0]       m_total;
    int                     m_pass;
    int                     m_cyc;

    task automatic model(input int len, input int hold, input bit abort);
        int L, H, tot;
        int s [OUT_W];
        bit done, fin;
        logic [OUT_W-1:0] e, o;
        L = (len == 0) ? 1 : len;
        H = (hold < IGN + 1) ? IGN + 1 : hold;
        foreach (s[c]) s[c] = 0;
        m_trace.delete();
        m_pass = 0;
        m_cyc  = 2;
        done   = 0;
        while (!done) begin
            tot = 0;
            foreach (s[c]) tot += s[c];
            fin = (m_pass == RET) || (tot > 0);
            for (int i = 0; i < L && !done; i++) begin
                m_cyc += H + 2;
                e = (err_m[i] != 0 && err_hi[i] >= IGN && err_lo[i] <= H - 1)
                    ? (err_m[i] & rom_val[i]) : '0;
                if (fin) begin
                    for (int k = 0; k < H; k++) begin
                        o = rom_exp[i] ^
                            ((k >= err_lo[i] && k <= err_hi[i]) ? err_m[i] : '0);
                        m_trace.push_back({rom_in[i], 8'(i), rom_exp[i], o});
                    end
                end
                for (int c = 0; c < OUT_W; c++)
                    if (e[c] && s[c] < (1 << SUM_W) - 1) s[c]++;
                if (abort && e != 0) done = 1;
            end
            if (!done) begin
                m_cyc++;
                tot = 0;
                foreach (s[c]) tot += s[c];
                done = !(tot == 0 && m_pass < RET);
                m_pass++;
            end
        end
        tot = 0;
        foreach (s[c]) tot += s[c];
        m_total = TOT_W'(tot);
        for (int c = 0; c < OUT_W; c++)
            m_sums[c*SUM_W +: SUM_W] = SUM_W'(s[c]);
    endtask

    task automatic prep(input logic [63:0] ents, input logic [OUT_W-1:0] mask,
                        input int lo, input int hi, input bit vclr);
        for (int i = 0; i < NS; i++) begin
            rom_in[i]  = IN_W'($urandom);
            rom_exp[i] = OUT_W'($urandom);
            rom_val[i] = '1;
            err_m[i]   = ents[i] ? mask : '0;
            err_lo[i]  = lo;
            err_hi[i]  = hi;
            if (ents[i] && vclr) rom_val[i] = ~mask;
        end
    endtask

    task automatic run_test(input string nm, input int len, input int hold,
                            input bit abort, input int xp_pass,
                            input int xp_total);
        int cyc, wr, tb, blanks;
        bit to;
        model(len, hold, abort);
        @(negedge clk);
        bus.iSeqLen     = (IDX_W+1)'(len);
        bus.iHoldCycles = CYC_W'(hold);
        bus.iEarlyAbort = abort;
        bus.iStart      = 1'b1;
        cyc = 0; wr = 0; tb = 0; blanks = 0; to = 0;
        do begin
            @(negedge clk);
            bus.iStart = 1'b0;
            cyc++;
            if (bus.oChromBlank) blanks++;
            if (bus.oTraceWe) begin
                if (wr >= m_trace.size() || bus.oTraceData !== m_trace[wr] ||
                    bus.oTraceAddr !== ADDR_W'(wr))
                    tb++;
                wr++;
            end
            if (cyc > 20000) to = 1;
        end while (!bus.oDone && !to);
        chk({nm, ".timeout"}, 64'(to), 0);
        chk({nm, ".cycles"}, cyc, m_cyc);
        chk({nm, ".pass"}, bus.oPassCount, m_pass);
        chk({nm, ".sums"}, bus.oErrorSums, m_sums);
        chk({nm, ".total"}, bus.oTotalErrors, m_total);
        chk({nm, ".writes"}, wr, m_trace.size());
        chk({nm, ".trace_bad"}, tb, 0);
        chk({nm, ".blank"}, blanks, 1);
        chk({nm, ".taddr"}, bus.oTraceAddr, ADDR_W'(m_trace.size()));
        if (xp_pass >= 0) begin
            chk({nm, ".tbl_pass"}, bus.oPassCount, xp_pass);
            chk({nm, ".tbl_total"}, bus.oTotalErrors, xp_total);
        end
        if (to) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end else begin
            bus.iStart = 1'b1;
            @(negedge clk);
            bus.iStart = 1'b0;
            chk({nm, ".start_ignored"}, bus.oDone, 1);
            bus.iDoneAck = 1'b1;
            @(negedge clk);
            bus.iDoneAck = 1'b0;
            chk({nm, ".ready"}, bus.oReady, 1);
        end
    endtask

    typedef struct {
        int               len;
        int               hold;
        bit               abort;
        logic [63:0]      ents;
        logic [OUT_W-1:0] mask;
        int               lo;
        int               hi;
        bit               vclr;
        int               xp_pass;
        int               xp_total;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int len, hold, lo, ok;
        bit ab;

        tbl[0]  = '{4,  20, 0, 64'h0,  8'h00, 0,  1000, 0, 4, 0};
        tbl[1]  = '{4,  20, 0, 64'h4,  8'h08, 0,  1000, 0, 1, 1};
        tbl[2]  = '{4,  20, 0, 64'h4,  8'h08, 0,  1000, 1, 4, 0};
        tbl[3]  = '{8,  20, 1, 64'h2,  8'h20, 0,  1000, 0, 0, 1};
        tbl[4]  = '{4,  20, 0, 64'h4,  8'h02, 0,  9,    0, 4, 0};
        tbl[5]  = '{6,  12, 0, 64'h1F, 8'h01, 0,  1000, 0, 1, 3};
        tbl[6]  = '{0,  0,  0, 64'h0,  8'h00, 0,  1000, 0, 4, 0};
        tbl[7]  = '{3,  11, 0, 64'h2,  8'h40, 10, 10,   0, 1, 1};
        tbl[8]  = '{4,  20, 0, 64'h8,  8'h80, 19, 19,   0, 1, 1};
        tbl[9]  = '{3,  15, 1, 64'h0,  8'h00, 0,  1000, 0, 4, 0};
        tbl[10] = '{5,  14, 1, 64'h1,  8'h81, 0,  1000, 0, 0, 2};
        tbl[11] = '{5,  13, 0, 64'h7,  8'h03, 0,  1000, 0, 1, 6};
        tbl[12] = '{64, 11, 0, 64'h8000000000000000, 8'h10, 0, 1000, 0, 1, 1};

        bus.iStart = 1'b0;
        bus.iDoneAck = 1'b0;
        bus.iSeqLen = '0;
        bus.iHoldCycles = '0;
        bus.iEarlyAbort = 1'b0;
        prep(64'h0, 8'h00, 0, 0, 0);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset.state", bus.oState, 0);
        chk("reset.ready", bus.oReady, 1);
        chk("reset.done", bus.oDone, 0);
        chk("reset.sums", bus.oErrorSums, 0);
        chk("reset.pass", bus.oPassCount, 0);
        chk("reset.taddr", bus.oTraceAddr, 0);
        chk("reset.stim", bus.oChromInput, 0);
        chk("reset.we_blank", {bus.oTraceWe, bus.oChromBlank}, 0);
        rst = 1'b0;

        for (int t = 0; t < 13; t++) begin
            prep(tbl[t].ents, tbl[t].mask, tbl[t].lo, tbl[t].hi, tbl[t].vclr);
            run_test($sformatf("tbl%0d", t), tbl[t].len, tbl[t].hold,
                     tbl[t].abort, tbl[t].xp_pass, tbl[t].xp_total);
        end

        for (int r = 0; r < 12; r++) begin
            len  = $urandom_range(0, 10);
            hold = $urandom_range(0, 25);
            ab   = 1'($urandom);
            prep(64'h0, 8'h00, 0, 0, 0);
            for (int i = 0; i < NS; i++) begin
                rom_val[i] = OUT_W'($urandom | $urandom);
                if ($urandom_range(0, 5) == 0) begin
                    lo        = $urandom_range(0, hold + 2);
                    err_m[i]  = OUT_W'($urandom);
                    err_lo[i] = lo;
                    err_hi[i] = lo + $urandom_range(0, 8);
                end
            end
            run_test($sformatf("rnd%0d", r), len, hold, ab, -1, 0);
        end

        // reset in the middle of a pass, after an error has been counted
        prep(64'h1, 8'h04, 0, 1000, 0);
        @(negedge clk);
        bus.iSeqLen = 7'd4;
        bus.iHoldCycles = 16'd20;
        bus.iEarlyAbort = 1'b0;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        ok = 0;
        for (int c = 0; c < 200 && ok == 0; c++) begin
            if (bus.oState == S_RUN && bus.oSampleIdx == 1) ok = 1;
            else @(negedge clk);
        end
        chk("rst_mid.reached", ok, 1);
        chk("rst_mid.pre_sums", bus.oErrorSums, 16'h0010);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.state", bus.oState, 0);
        chk("rst_mid.ready", bus.oReady, 1);
        chk("rst_mid.sums", bus.oErrorSums, 0);
        chk("rst_mid.total", bus.oTotalErrors, 0);
        chk("rst_mid.misc", {bus.oPassCount, bus.oTraceAddr, bus.oChromInput,
                             bus.oSampleIdx, bus.oTraceWe, bus.oChromBlank,
                             bus.oDone}, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/chrom_eval_sequencer.md
Name: chrom_eval_sequencer

Overview:
Parametrised successor to the chromosome-evaluation state machine. Drives a test-input sequence into an external phenotype circuit, holds each input for a runtime-selected number of cycles, and samples the circuit output against expected/valid masks after a settle window. Keeps saturating per-output-bit error counts, re-runs the whole sequence NUM_RETRIES extra times while it stays error-free, and can abort early on the first failing input. Streams a trace of the final pass to an external RAM. Sits between the GA controller (start/done handshake) and the phenotype instance.

Parameters:
IN_W, 8, phenotype input width
OUT_W, 8, phenotype output width (error channels)
NUM_SAMPLES, 64, max sequence entries; IDX_W = $clog2(NUM_SAMPLES)
SUM_W, 32, per-channel error counter width (saturating)
CYC_W, 16, hold-cycle counter width
IGNORE_CYCLES, 10, settle cycles per input before sampling starts
NUM_RETRIES, 3, extra passes after a clean pass
ADDR_W, 15, trace RAM address width

Ports:
iClock in 1 clock
iReset in 1 reset, synchronous, active-high
iStart in 1 start request, sampled in IDLE
iDoneAck in 1 acknowledge, returns DONE to IDLE
oReady out 1 high in IDLE
oDone out 1 high in DONE
iSeqLen in IDX_W+1 entries to run, 1..NUM_SAMPLES, latched on start
iHoldCycles in CYC_W cycles per input, latched on start
iEarlyAbort in 1 latched on start; 1 = stop at first failing entry
oSampleIdx out IDX_W current entry index to external sample ROM
iSampleIn in IN_W stimulus for oSampleIdx (combinational lookup)
iSampleExp in OUT_W expected output
iSampleValid in OUT_W per-bit compare enable
oChromInput out IN_W registered stimulus to phenotype
oChromBlank out 1 force phenotype description to zero
iChromOutput in OUT_W phenotype output
oErrorSums out OUT_W*SUM_W per-channel failing-entry counts
oTotalErrors out SUM_W+$clog2(OUT_W) sum of channels
oPassCount out 3 passes completed
oState out 3 state code
oTraceWe out 1 trace write strobe
oTraceAddr out ADDR_W trace address
oTraceData out 2*IDX_W.. packed {input, index, expected, output}, IN_W+8+2*OUT_W bits, index zero-extended to 8

Behaviour:
- Reset: state IDLE; all counters, sums, oPassCount, oTraceAddr, oChromInput = 0; oTraceWe = 0; oChromBlank = 0. Reset wins over every other event, including mid-pass.
- States: IDLE, BLANK, LOAD, RUN, ACCUM, CHECK, DONE.
- IDLE: oReady = 1. On iStart: latch config; clear sums, pass count, index; go BLANK. iSeqLen = 0 is treated as 1; iHoldCycles below IGNORE_CYCLES+1 is clamped to IGNORE_CYCLES+1.
- BLANK: one cycle, oChromBlank = 1, clears phenotype state; oTraceAddr <= 0; go LOAD.
- LOAD: oChromInput <= iSampleIn; clear per-entry mismatch flags and cycle counter; go RUN. One cycle of latency from index change to stimulus.
- RUN: counter increments each cycle. When counter >= IGNORE_CYCLES, per-bit flag |= (iChromOutput ^ iSampleExp) & iSampleValid. On the final pass only, oTraceWe = 1 every RUN cycle; address increments and wraps mod 2^ADDR_W. When counter == hold-1, go ACCUM.
- ACCUM: each channel sum += flag bit, saturating at 2^SUM_W-1. Then:
  - if early abort is set and any flag is set -> DONE;
  - else if index == len-1 -> CHECK;
  - else index++ -> LOAD.
- CHECK: if total == 0 and pass count < NUM_RETRIES: pass count++, index = 0 -> LOAD. Otherwise pass count++ and go DONE.
- Final pass: pass count == NUM_RETRIES, or any pass in which an error is already present (total > 0 at entry to LOAD of index 0).
- DONE: oDone = 1; outputs hold. On iDoneAck -> IDLE. iStart is ignored outside IDLE.
- oTotalErrors is combinational from the registered sums.

Decomposition:
- Package chrom_eval_pkg: state enum, trace-word packing function, clamp constants.
- Sub-module chrom_err_accum: OUT_W saturating counters with clear and increment-vector inputs; used once.

Test Plan:
- Outputs always match, len 4, hold 20 -> 4 passes, sums 0, oPassCount 4, DONE after 4*(4*22)+~6 cycles, trace written only in the last pass: 80 writes, addr 0..79.
- Channel 3 wrong on entry 2, valid bit set -> oErrorSums[3] = 1, others 0, no retry, oPassCount 1.
- Same mismatch with valid bit 3 clear -> sums 0, retries occur.
- Early abort, mismatch on entry 1 of 8 -> DONE after entry 1, oErrorSums[ch] = 1.
- Mismatch only during the first 10 cycles after LOAD -> ignored, sums 0.
- SUM_W = 2, errors on 5 entries -> sum saturates at 3. Reset asserted mid-RUN -> IDLE, all outputs 0 next cycle.
